div_unit: RTL and testbench

- Parametrised multi-cycle radix-2 restoring divider for the EX stage. Successor to the two-cycle madd/msub temp-accumulate scheme.
- EX raises start_i and holds its stall request until ready_o, then writes {remainder, quotient} to HI/LO.
- Generalised in operand width. Supports signed and unsigned modes, divide-by-zero detection, and annul (flush) mid-operation.

---
 rtl/div_unit.sv | 88 ++++++++
 tb/tb_div_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider, signed/unsigned, divide-by-zero and annul support
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               Rst_n,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dividend, divisor, rem, quo;
  logic sign_q, sign_r;
  logic [WIDTH:0] shifted, diff;
  assign shifted = {rem, dividend[WIDTH-1]};
  assign diff = shifted - {1'b0, divisor};
  assign busy_o = state == ON || state == BY_ZERO;
  always_comb begin
    next = state;
    case (state)
      FREE:    if (!annul_i && start_i) next = opdata2_i == '0 ? BY_ZERO : ON;
      BY_ZERO: next = annul_i ? FREE : END;
      ON:      next = annul_i ? FREE : cnt == LAST ? END : ON;
      END:     next = annul_i || !start_i ? FREE : END;
      default: next = FREE;
    endcase
  end
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) state <= FREE;
    else state <= next;
  // Operands are stored as magnitudes; signs are restored once all quotient bits are in.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
      dividend <= '0;
      divisor <= '0;
      rem <= '0;
      quo <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      ready_o <= 1'b0;
      result_o <= '0;
    end else begin
      ready_o <= 1'b0;
      result_o <= '0;
      case (state)
        FREE: if (start_i && !annul_i) begin
          cnt <= '0;
          rem <= '0;
          quo <= '0;
          dividend <= signed_div_i && opdata1_i[WIDTH-1] ? -opdata1_i : opdata1_i;
          divisor <= signed_div_i && opdata2_i[WIDTH-1] ? -opdata2_i : opdata2_i;
          sign_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          sign_r <= signed_div_i && opdata1_i[WIDTH-1];
        end
        BY_ZERO: begin
          rem <= '0;
          quo <= '0;
        end
        ON: if (!annul_i) begin
          if (cnt != LAST) begin
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            dividend <= dividend << 1;
            cnt <= cnt + CNT_W'(1);
          end else begin
            quo <= sign_q ? -quo : quo;
            rem <= sign_r ? -rem : rem;
          end
        end
        END: if (start_i && !annul_i) begin
          ready_o <= 1'b1;
          result_o <= {rem, quo};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit at WIDTH=32 and WIDTH=8
module tb_div_unit;
  logic clk = 0, Rst_n = 0;
  logic sd = 0, start = 0, annul = 0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] res;
  logic rdy, bsy;
  logic sd8 = 0, start8 = 0, annul8 = 0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic rdy8, bsy8;
  int checks = 0, errors = 0;
  div_unit #(.WIDTH(32), .CNT_W(6)) d32 (.clk(clk), .Rst_n(Rst_n), .signed_div_i(sd), .opdata1_i(a),
    .opdata2_i(b), .start_i(start), .annul_i(annul), .result_o(res), .ready_o(rdy), .busy_o(bsy));
  div_unit #(.WIDTH(8), .CNT_W(4)) d8 (.clk(clk), .Rst_n(Rst_n), .signed_div_i(sd8), .opdata1_i(a8),
    .opdata2_i(b8), .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8), .busy_o(bsy8));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run32(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input int lat);
    int n, nb;
    @(posedge clk); #1;
    sd = s; a = x; b = y; start = 1; n = 0; nb = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      if (rdy) break;
      if (bsy) nb++;
      if (n == 0) begin a = ~x; b = '0; end
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " result"}, res, exp);
    chk({tag, " busy cycles"}, 64'(nb), 64'(lat - 1));
    @(posedge clk); #1;
    chk({tag, " held ready"}, 64'(rdy), 64'(1));
    chk({tag, " held result"}, res, exp);
    start = 0;
    @(posedge clk); #1;
    chk({tag, " drop ready"}, 64'(rdy), 64'(0));
    chk({tag, " drop result"}, res, 64'(0));
  endtask
  initial begin
    int n;
    #2;
    chk("reset ready", 64'(rdy), 64'(0));
    chk("reset busy", 64'(bsy), 64'(0));
    chk("reset result", res, 64'(0));
    chk("reset result8", 64'(res8), 64'(0));
    #10 Rst_n = 1;
    run32("u 100/7", 0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    run32("s -7/2", 1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
    run32("s 7/-2", 1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 34);
    run32("s -100/-7", 1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 34);
    run32("u FFFFFFF9/2", 0, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 34);
    run32("div0", 0, 32'h1234, 32'd0, 64'd0, 2);
    run32("s ovf", 1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 34);
    run32("u max/1", 0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 34);
    @(posedge clk); #1;
    sd = 0; a = 32'd100; b = 32'd7; start = 1;
    repeat (11) @(posedge clk);
    #1 annul = 1;
    @(posedge clk); #1;
    chk("annul busy", 64'(bsy), 64'(0));
    chk("annul ready", 64'(rdy), 64'(0));
    chk("annul result", res, 64'(0));
    annul = 0; start = 0; n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy) n++;
    end
    chk("annul no ready", 64'(n), 64'(0));
    run32("u 9/3", 0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);
    @(posedge clk); #1;
    sd = 0; a = 32'd100; b = 32'd7; start = 1;
    repeat (21) @(posedge clk);
    #3 Rst_n = 0;
    #1;
    chk("midreset busy", 64'(bsy), 64'(0));
    chk("midreset ready", 64'(rdy), 64'(0));
    chk("midreset result", res, 64'(0));
    start = 0;
    #3 Rst_n = 1;
    run32("u 100/7 again", 0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    @(posedge clk); #1;
    a8 = 8'd200; b8 = 8'd13; start8 = 1; n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      if (rdy8) break;
      n++;
    end
    chk("w8 latency", 64'(n), 64'(10));
    chk("w8 result", 64'(res8), 64'(16'h050F));
    start8 = 0;
    @(posedge clk); #1;
    chk("w8 drop ready", 64'(rdy8), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
